full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder.sv | 124 ++++++++++++
 tb/tb_full_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// ============================================================================
// Module   : full_adder
// Brief    : WIDTH-bit ripple-carry adder with optional one-cycle output register.
//            Define FULL_ADDER_CHECK_EN to add a sticky err output fed by a
//            behavioural reference comparison.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic             Cout,
    output logic [WIDTH-1:0] S,
    output logic             out_valid
`ifdef FULL_ADDER_CHECK_EN
    ,
    output logic             err
`endif
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = Cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            logic w_prop;
            assign w_prop       = A[i] ^ B[i];
            assign w_sum[i]     = w_prop ^ w_carry[i];
            assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & w_prop);
        end
    endgenerate

    generate
        if (REG_OUT) begin : g_reg_out
            logic [WIDTH-1:0] r_s_q;
            logic [WIDTH-1:0] w_s_d;
            logic             r_cout_q;
            logic             w_cout_d;
            logic             r_valid_q;

            // Result registers hold while no new operands arrive.
            assign w_s_d    = in_valid ? w_sum : r_s_q;
            assign w_cout_d = in_valid ? w_carry[WIDTH] : r_cout_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s_q     <= '0;
                    r_cout_q  <= 1'b0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_s_q     <= w_s_d;
                    r_cout_q  <= w_cout_d;
                    r_valid_q <= in_valid;
                end
            end

            assign S         = r_s_q;
            assign Cout      = r_cout_q;
            assign out_valid = r_valid_q;
        end else begin : g_comb_out
            assign S         = w_sum;
            assign Cout      = w_carry[WIDTH];
            assign out_valid = in_valid;
        end
    endgenerate

`ifdef FULL_ADDER_CHECK_EN
    logic [WIDTH:0] w_ref;
    logic [WIDTH:0] w_ref_cmp;
    logic           w_mismatch;
    logic           r_err_q;
    logic           w_err_d;

    assign w_ref = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};

    generate
        if (REG_OUT) begin : g_ref_reg
            logic [WIDTH:0] r_ref_q;
            logic [WIDTH:0] w_ref_d;

            // Reference is pipelined alongside the datapath so it lines up with out_valid.
            assign w_ref_d = in_valid ? w_ref : r_ref_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ref_q <= '0;
                end else begin
                    r_ref_q <= w_ref_d;
                end
            end

            assign w_ref_cmp = r_ref_q;
        end else begin : g_ref_comb
            assign w_ref_cmp = w_ref;
        end
    endgenerate

    assign w_mismatch = out_valid && ({Cout, S} != w_ref_cmp);
    assign w_err_d    = r_err_q | w_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_q <= 1'b0;
        end else begin
            r_err_q <= w_err_d;
        end
    end

    assign err = r_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: combinational and registered variants at several widths.
`default_nettype none

module tb_full_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a1, b1, c1, v1;
    logic       u1c_cout, u1c_s, u1c_ov;
    logic       u1r_cout, u1r_s, u1r_ov;
    logic [7:0] a8, b8, s8;
    logic       c8, v8, cout8, ov8;
    logic [3:0] a4, b4, s4;
    logic       c4, v4, cout4, ov4;
`ifdef FULL_ADDER_CHECK_EN
    logic       err1c, err1r, err8, err4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_1c (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .in_valid(v1),
        .Cout(u1c_cout), .S(u1c_s), .out_valid(u1c_ov)
`ifdef FULL_ADDER_CHECK_EN
        , .err(err1c)
`endif
    );

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_1r (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .in_valid(v1),
        .Cout(u1r_cout), .S(u1r_s), .out_valid(u1r_ov)
`ifdef FULL_ADDER_CHECK_EN
        , .err(err1r)
`endif
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .in_valid(v8),
        .Cout(cout8), .S(s8), .out_valid(ov8)
`ifdef FULL_ADDER_CHECK_EN
        , .err(err8)
`endif
    );

    full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .in_valid(v4),
        .Cout(cout4), .S(s4), .out_valid(ov4)
`ifdef FULL_ADDER_CHECK_EN
        , .err(err4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {Cout,S} for {A,B,Cin} = 000..111
    logic [1:0] exp_w1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // WIDTH=4 stream: {A, B, Cin} and hand-computed {Cout,S}
    logic [8:0] vec4 [16] = '{
        {4'h3, 4'h4, 1'b0}, {4'hF, 4'h1, 1'b0}, {4'h9, 4'h9, 1'b1}, {4'h0, 4'h0, 1'b1},
        {4'hA, 4'h5, 1'b0}, {4'hA, 4'h5, 1'b1}, {4'h7, 4'h8, 1'b1}, {4'hC, 4'hD, 1'b0},
        {4'hE, 4'h2, 1'b1}, {4'h1, 4'h6, 1'b0}, {4'hB, 4'hB, 1'b1}, {4'hF, 4'hF, 1'b1},
        {4'h8, 4'h8, 1'b0}, {4'h2, 4'h3, 1'b1}, {4'hD, 4'h0, 1'b1}, {4'h6, 4'h9, 1'b0}};
    logic [4:0] exp4 [16] = '{
        5'h07, 5'h10, 5'h13, 5'h01, 5'h0F, 5'h10, 5'h10, 5'h19,
        5'h11, 5'h07, 5'h17, 5'h1F, 5'h10, 5'h06, 5'h0E, 5'h0F};

    initial begin
        rst = 1'b1;
        {a1, b1, c1, v1} = '0;
        {a8, b8, c8, v8} = '0;
        {a4, b4, c4, v4} = '0;
        tick();
        tick();

        check("rst_u1r", {u1r_cout, u1r_s, u1r_ov}, 3'b000);
        check("rst_u8",  {cout8, s8, ov8}, 10'h000);
        check("rst_u4",  {cout4, s4, ov4}, 6'h00);
`ifdef FULL_ADDER_CHECK_EN
        check("rst_err", {err1c, err1r, err8, err4}, 4'b0000);
`endif
        rst = 1'b0;

        // Combinational truth-table sweep
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            v1 = 1'b1;
            #1;
            check($sformatf("w1c_sum_%0d", i), {u1c_cout, u1c_s}, exp_w1[i]);
            check($sformatf("w1c_ov_%0d", i), u1c_ov, 1'b1);
        end

        // Registered 1-bit: result one cycle later
        {a1, b1, c1, v1} = 4'b1111;
        tick();
        check("w1r_111", {u1r_cout, u1r_s, u1r_ov}, 3'b111);
        {a1, b1, c1, v1} = 4'b0000;
        #1;
        check("w1c_ov_low", u1c_ov, 1'b0);
        tick();
        check("w1r_hold", {u1r_cout, u1r_s, u1r_ov}, 3'b110);

        // WIDTH=8 boundaries, back-to-back
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
        tick();
        check("w8_ff_01", {cout8, s8, ov8}, {9'h100, 1'b1});
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        tick();
        check("w8_ovf", {cout8, s8, ov8}, {9'h1FF, 1'b1});
        a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b1;
        tick();
        check("w8_5a_3c", {cout8, s8, ov8}, {9'h097, 1'b1});

        // Reset beats in_valid; mid-stream result is dropped
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b1; v8 = 1'b1;
        {a1, b1, c1, v1} = 4'b1111;
        rst = 1'b1;
        tick();
        check("w8_rst_pri", {cout8, s8, ov8}, 10'h000);
        check("w1r_rst_pri", {u1r_cout, u1r_s, u1r_ov}, 3'b000);
        check("w1c_rst_noeff", {u1c_cout, u1c_s, u1c_ov}, 3'b111);
        rst = 1'b0;
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; v8 = 1'b1;
        v1 = 1'b0;
        tick();
        check("w8_after_rst", {cout8, s8, ov8}, {9'h030, 1'b1});
        v8 = 1'b0;
        tick();
        check("w8_hold", {cout8, s8, ov8}, {9'h030, 1'b0});

        // WIDTH=4 continuous stream
        v4 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            {a4, b4, c4} = vec4[k];
            tick();
            check($sformatf("w4_stream_%0d", k), {cout4, s4, ov4}, {exp4[k], 1'b1});
        end
        v4 = 1'b0;
        tick();
        check("w4_ov_drop", ov4, 1'b0);

`ifdef FULL_ADDER_CHECK_EN
        // Exhaustive WIDTH=4 sweep; sticky err must stay clear
        v4 = 1'b1;
        for (int j = 0; j < 512; j++) begin
            {a4, b4, c4} = 9'(j);
            tick();
            check($sformatf("w4_err_%0d", j), err4, 1'b0);
        end
        v4 = 1'b0;
        tick();
        tick();
        check("err_final", {err1c, err1r, err8, err4}, 4'b0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
